// File: rtl/delay_line_sel.sv
// Selectable-delay line: DEPTH registered stages of WIDTH-bit data plus valid,
// with a combinational tap mux choosing 0..DEPTH shift cycles of delay.
module delay_line_sel #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 3,
   localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             sel_clamped,
   output logic [SEL_W-1:0] fill
);

   logic [WIDTH-1:0] s [1:DEPTH];
   logic [DEPTH:1]   v;

   // Stage chain and saturating fill counter; flush beats en and drops d.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int k = 1; k <= DEPTH; k++) s[k] <= '0;
         v    <= '0;
         fill <= '0;
      end else if (flush) begin
         for (int k = 1; k <= DEPTH; k++) s[k] <= '0;
         v    <= '0;
         fill <= '0;
      end else if (en) begin
         s[1] <= d;
         v[1] <= d_valid;
         for (int k = 2; k <= DEPTH; k++) begin
            s[k] <= s[k-1];
            v[k] <= v[k-1];
         end
         if (fill != SEL_W'(DEPTH)) fill <= fill + SEL_W'(1);
      end
   end

   // Tap mux: sel=0 is the live input, out-of-range selects pin to the last stage.
   always_comb begin
      q           = d;
      q_valid     = d_valid;
      sel_clamped = 1'b0;
      if (32'(sel) > DEPTH) begin
         q           = s[DEPTH];
         q_valid     = v[DEPTH];
         sel_clamped = 1'b1;
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
               q       = s[k];
               q_valid = v[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_line_sel.sv
// Scoreboard bench for delay_line_sel: a DEPTH=3 and a DEPTH=5 instance share
// stimulus; expected taps are queued as stimulus is driven and checked on output.
module tb_delay_line_sel;

   typedef struct packed {
      logic [7:0] q;
      logic       qv;
      logic       cl;
      logic [2:0] fill;
   } exp_t;

   logic       clk = 1'b0;
   logic       areset, en, flush, d_valid;
   logic [7:0] d;
   logic [1:0] sel3;
   logic [2:0] sel5;
   logic [7:0] q3, q5;
   logic       qv3, qv5, cl3, cl5;
   logic [1:0] fill3;
   logic [2:0] fill5;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   delay_line_sel #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk(clk), .areset(areset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .sel(sel3), .q(q3), .q_valid(qv3), .sel_clamped(cl3), .fill(fill3)
   );

   delay_line_sel #(.WIDTH(8), .DEPTH(5)) dut5 (
      .clk(clk), .areset(areset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .sel(sel5), .q(q5), .q_valid(qv5), .sel_clamped(cl5), .fill(fill5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1; en = 1'b0; flush = 1'b0;
      d = 8'h3C; d_valid = 1'b1; sel3 = 2'd1; sel5 = 3'd1;
      sb.push_back('{q: 8'h00, qv: 1'b0, cl: 1'b0, fill: 3'd0});
      #2;
      e = sb.pop_front();
      vectors++;
      if (q3 !== e.q || qv3 !== e.qv || {1'b0, fill3} !== e.fill) begin
         miscompares++;
         $display("FAIL reset3: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d", q3, qv3, fill3, e.q, e.qv, e.fill);
      end
      vectors++;
      if (q5 !== e.q || qv5 !== e.qv || fill5 !== e.fill) begin
         miscompares++;
         $display("FAIL reset5: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d", q5, qv5, fill5, e.q, e.qv, e.fill);
      end
      // sel=0 passes d straight through even while reset is held
      sel3 = 2'd0;
      sb.push_back('{q: 8'h3C, qv: 1'b1, cl: 1'b0, fill: 3'd0});
      #1;
      e = sb.pop_front();
      vectors++;
      if (q3 !== e.q || qv3 !== e.qv) begin
         miscompares++;
         $display("FAIL reset_sel0: q=%h qv=%b, expected q=%h qv=%b", q3, qv3, e.q, e.qv);
      end
   endtask

   task automatic test_fill();
      logic [7:0] din [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_t       ex  [4] = '{'{8'h00, 1'b0, 1'b0, 3'd1}, '{8'h00, 1'b0, 1'b0, 3'd2},
                            '{8'h11, 1'b1, 1'b0, 3'd3}, '{8'h22, 1'b1, 1'b0, 3'd3}};
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      sel3 = 2'd3; en = 1'b1; d_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = din[i];
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || qv3 !== e.qv || {1'b0, fill3} !== e.fill) begin
            miscompares++;
            $display("FAIL fill edge%0d: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d",
                     i + 1, q3, qv3, fill3, e.q, e.qv, e.fill);
         end
      end
   endtask

   task automatic test_tap_sweep();
      logic [7:0] din [3] = '{8'hA1, 8'hB2, 8'hC3};
      logic [7:0] tap [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      en = 1'b1; d_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = din[i];
         tick();
      end
      en = 1'b0; d = 8'hD4;
      for (int i = 0; i < 4; i++) begin
         sel3 = 2'(i);
         sb.push_back('{q: tap[i], qv: 1'b1, cl: 1'b0, fill: 3'd3});
         #1;
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || qv3 !== e.qv || cl3 !== e.cl) begin
            miscompares++;
            $display("FAIL sweep sel=%0d: q=%h qv=%b cl=%b, expected q=%h qv=%b cl=%b",
                     i, q3, qv3, cl3, e.q, e.qv, e.cl);
         end
      end
      // a held edge must leave every stage untouched
      tick();
      for (int i = 1; i < 4; i++) begin
         sel3 = 2'(i);
         sb.push_back('{q: tap[i], qv: 1'b1, cl: 1'b0, fill: 3'd3});
         #1;
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || {1'b0, fill3} !== e.fill) begin
            miscompares++;
            $display("FAIL sweep_hold sel=%0d: q=%h fill=%0d, expected q=%h fill=%0d", i, q3, fill3, e.q, e.fill);
         end
      end
   endtask

   task automatic test_enable_gaps();
      sel3 = 2'd2; en = 1'b1; d = 8'h5A; d_valid = 1'b1;
      sb.push_back('{q: 8'hC3, qv: 1'b1, cl: 1'b0, fill: 3'd3});
      tick();
      en = 1'b0; d = 8'hEE;
      for (int i = 0; i < 4; i++) sb.push_back('{q: 8'hC3, qv: 1'b1, cl: 1'b0, fill: 3'd3});
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || qv3 !== e.qv) begin
            miscompares++;
            $display("FAIL gap cycle%0d: q=%h qv=%b, expected q=%h qv=%b", i, q3, qv3, e.q, e.qv);
         end
      end
      en = 1'b1; d = 8'h00; d_valid = 1'b0;
      sb.push_back('{q: 8'h5A, qv: 1'b1, cl: 1'b0, fill: 3'd3});
      tick();
      e = sb.pop_front();
      vectors++;
      if (q3 !== e.q || qv3 !== e.qv) begin
         miscompares++;
         $display("FAIL gap resume: q=%h qv=%b, expected q=%h qv=%b", q3, qv3, e.q, e.qv);
      end
   endtask

   task automatic test_valid_bubbles();
      logic [7:0] din [3] = '{8'h01, 8'h02, 8'h03};
      logic       vin [3] = '{1'b1, 1'b0, 1'b1};
      sel3 = 2'd1; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = din[i]; d_valid = vin[i];
         sb.push_back('{q: din[i], qv: vin[i], cl: 1'b0, fill: 3'd3});
         tick();
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || qv3 !== e.qv) begin
            miscompares++;
            $display("FAIL bubble%0d: q=%h qv=%b, expected q=%h qv=%b", i, q3, qv3, e.q, e.qv);
         end
      end
   endtask

   task automatic test_flush_vs_en();
      flush = 1'b1; en = 1'b1; d = 8'hFF; d_valid = 1'b1;
      tick();
      flush = 1'b0; en = 1'b0; d = 8'h00; d_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         sel3 = 2'(i);
         sb.push_back('{q: 8'h00, qv: 1'b0, cl: 1'b0, fill: 3'd0});
         #1;
         e = sb.pop_front();
         vectors++;
         if (q3 !== e.q || qv3 !== e.qv || {1'b0, fill3} !== e.fill) begin
            miscompares++;
            $display("FAIL flush sel=%0d: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d",
                     i, q3, qv3, fill3, e.q, e.qv, e.fill);
         end
      end
      vectors++;
      if (fill5 !== 3'd0) begin
         miscompares++;
         $display("FAIL flush fill5: fill=%0d, expected 0", fill5);
      end
   endtask

   task automatic test_async_reset_clamp();
      logic [7:0] din [3] = '{8'h10, 8'h20, 8'h30};
      sel5 = 3'd1; en = 1'b1; d_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = din[i];
         sb.push_back('{q: din[i], qv: 1'b1, cl: 1'b0, fill: 3'(i + 1)});
         tick();
         e = sb.pop_front();
         vectors++;
         if (q5 !== e.q || qv5 !== e.qv || fill5 !== e.fill) begin
            miscompares++;
            $display("FAIL stream5 %0d: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d",
                     i, q5, qv5, fill5, e.q, e.qv, e.fill);
         end
      end
      // reset between edges must clear outputs without a clock
      #2 areset = 1'b1;
      sb.push_back('{q: 8'h00, qv: 1'b0, cl: 1'b0, fill: 3'd0});
      #1;
      e = sb.pop_front();
      vectors++;
      if (q5 !== e.q || qv5 !== e.qv || fill5 !== e.fill) begin
         miscompares++;
         $display("FAIL async_reset: q=%h qv=%b fill=%0d, expected q=%h qv=%b fill=%0d", q5, qv5, fill5, e.q, e.qv, e.fill);
      end
      @(negedge clk);
      areset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d = 8'h61 + 8'(i);
         sb.push_back('{q: d, qv: 1'b1, cl: 1'b0, fill: (i < 5) ? 3'(i + 1) : 3'd5});
         tick();
         e = sb.pop_front();
         vectors++;
         if (q5 !== e.q || fill5 !== e.fill) begin
            miscompares++;
            $display("FAIL refill %0d: q=%h fill=%0d, expected q=%h fill=%0d", i, q5, fill5, e.q, e.fill);
         end
      end
      en = 1'b0; d = 8'h77;
      for (int s = 5; s < 9; s++) begin
         sel5 = 3'(s);
         if (s == 8) sb.push_back('{q: 8'h77, qv: 1'b1, cl: 1'b0, fill: 3'd5});
         else        sb.push_back('{q: 8'h62, qv: 1'b1, cl: (s > 5), fill: 3'd5});
         #1;
         e = sb.pop_front();
         vectors++;
         if (q5 !== e.q || qv5 !== e.qv || cl5 !== e.cl) begin
            miscompares++;
            $display("FAIL clamp sel=%0d: q=%h qv=%b cl=%b, expected q=%h qv=%b cl=%b",
                     sel5, q5, qv5, cl5, e.q, e.qv, e.cl);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ms [1:5];
      logic       mv [1:5];
      logic [2:0] mfill;
      areset = 1'b1;
      #1;
      for (int k = 1; k <= 5; k++) begin ms[k] = '0; mv[k] = 1'b0; end
      mfill = '0;
      @(negedge clk);
      areset = 1'b0;
      for (int n = 0; n < 300; n++) begin
         en = ($urandom_range(3) != 0);
         flush = ($urandom_range(15) == 0);
         d = 8'($urandom);
         d_valid = 1'($urandom);
         sel5 = 3'($urandom_range(7));
         if (sel5 == 3'd0)     sb.push_back('{q: d, qv: d_valid, cl: 1'b0, fill: mfill});
         else if (sel5 > 3'd5) sb.push_back('{q: ms[5], qv: mv[5], cl: 1'b1, fill: mfill});
         else                  sb.push_back('{q: ms[sel5], qv: mv[sel5], cl: 1'b0, fill: mfill});
         #1;
         e = sb.pop_front();
         vectors++;
         if (q5 !== e.q || qv5 !== e.qv || cl5 !== e.cl || fill5 !== e.fill) begin
            miscompares++;
            $display("FAIL random %0d sel=%0d: q=%h qv=%b cl=%b fill=%0d, expected q=%h qv=%b cl=%b fill=%0d",
                     n, sel5, q5, qv5, cl5, fill5, e.q, e.qv, e.cl, e.fill);
         end
         if (flush) begin
            for (int k = 1; k <= 5; k++) begin ms[k] = '0; mv[k] = 1'b0; end
            mfill = '0;
         end else if (en) begin
            for (int k = 5; k >= 2; k--) begin ms[k] = ms[k-1]; mv[k] = mv[k-1]; end
            ms[1] = d; mv[1] = d_valid;
            if (mfill < 3'd5) mfill = mfill + 3'd1;
         end
         tick();
      end
      flush = 1'b0; en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_tap_sweep();
      test_enable_gaps();
      test_valid_bubbles();
      test_flush_vs_en();
      test_async_reset_clamp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/delay_line_sel.md
# delay_line_sel

Parameterised selectable-delay line: a chain of DEPTH registered stages, each WIDTH bits plus a valid flag, with a run-time tap select that picks a delay of 0 to DEPTH shift cycles. It generalises the fixed 8-bit, 3-stage delay selector to any width and depth. It adds a shift enable, synchronous flush, per-stage valid tracking and a saturating fill counter. It sits on datapaths that need to align a stream against a variable-latency partner.

## Interface

- WIDTH, 8: data width in bits (≥1).
- DEPTH, 3: number of stages, which is also the maximum delay (≥1).
- SEL_W, $clog2(DEPTH+1): derived width of sel and fill. Treat as localparam; do not override.

- clk  input  1  single clock, rising edge.
- areset  input  1  asynchronous reset, active-high.
- en  input  1  shift enable; stages advance only when high.
- flush  input  1  synchronous clear of all stages and the fill counter.
- d  input  WIDTH  input data.
- d_valid  input  1  qualifies d; shifted alongside it.
- sel  input  SEL_W  tap select: 0 = input, k = stage k.
- q  output  WIDTH  selected tap data.
- q_valid  output  1  selected tap valid.
- sel_clamped  output  1  high when sel > DEPTH.
- fill  output  SEL_W  en cycles since reset/flush, saturating at DEPTH.

## Operation

- State: stage data s[1..DEPTH], stage valid v[1..DEPTH], counter fill.
- Priority per rising edge, highest first: areset, flush, en, hold.
- areset (async, any time): all s to 0, all v to 0, fill to 0. This applies immediately and is held while areset is high.
- flush (sync): same clear as reset. It overrides en in the same cycle, and the d/d_valid presented that cycle is discarded.
- en=1, flush=0: s[1]<=d and v[1]<=d_valid; s[k]<=s[k-1] and v[k]<=v[k-1] for k=2..DEPTH. s[DEPTH] is dropped. fill<=min(fill+1, DEPTH).
- en=0, flush=0: all state holds and fill holds.
- Invalid words (d_valid=0) still shift. Data bits travel regardless of valid; only v marks them.
- Output mux (purely combinational, no registers):
  - sel=0: q=d, q_valid=d_valid.
  - 1≤sel≤DEPTH: q=s[sel], q_valid=v[sel].
  - sel>DEPTH (possible only when DEPTH+1 is not a power of two): q=s[DEPTH], q_valid=v[DEPTH], sel_clamped=1.
  - Otherwise sel_clamped=0.
- Changing sel takes effect immediately. It never disturbs stage contents, so the output jumps to the newly selected tap in the same cycle.
- fill saturates at DEPTH, never wraps, and is cleared only by reset or flush.

## Timing

- Reset values: s=0, v=0, fill=0. q=0 and q_valid=0 for sel≥1. For sel=0, q and q_valid follow d and d_valid even during reset.
- Latency for sel=k (k≥1): a word accepted on edge N (en=1) appears at q after the k-th en-qualified edge counting from N. Cycles with en=0 add no delay stages, only wall-clock time.
- sel=0: zero-cycle combinational path from d to q.
- Simultaneous flush and en on one edge: flush wins; afterwards fill=0 and all v=0.
- areset deasserting: the first edge with areset low may shift normally.
- Reset mid-stream: all in-flight words are lost, and q_valid drops immediately, asynchronously, for sel≥1.
- Data in stage k after fill≥k is real history. Before that it is reset or flush zero, with v=0.

## Test plan

- Reset/fill (WIDTH=8, DEPTH=3, sel=3): pulse areset, then en=1 with d=0x11,0x22,0x33,0x44 all valid -> q_valid=0 for the first 2 edges; after edge 3 q=0x11, q_valid=1; after edge 4 q=0x22; fill reads 1,2,3,3.
- Tap sweep: fill the line with 0xA1,0xB2,0xC3 and hold en=0, d=0xD4 -> sel=0..3 gives q=0xD4,0xC3,0xB2,0xA1 in the same cycle each; contents unchanged after the sweep.
- Enable gaps: sel=2, shift 0x5A, then en=0 for 4 cycles, then en=1 once -> q=0x5A only after the second en edge; held stable through the gap.
- Valid bubbles: sel=1, stream d_valid=1,0,1 with d=0x01,0x02,0x03 -> q_valid sequence 1,0,1 and q=0x01,0x02,0x03 one cycle later.
- Flush vs en: full line, assert flush=1 and en=1 together with d=0xFF -> next cycle fill=0, q=0, q_valid=0 for sel=1..3; 0xFF never appears.
- Async reset mid-stream and clamp (DEPTH=5, SEL_W=3): while streaming, assert areset between edges -> q and q_valid go to 0 before the next edge. After refill, sel=7 -> q=s[5], sel_clamped=1.
